// File: rtl/frame_l3_tx.sv
// frame_l3_tx - IPv4 transmit framer.
//
// Takes one L4 payload byte stream per frame together with per-frame header
// fields. It emits a 20-byte IPv4 header (no options) carrying the computed
// header checksum, then forwards the payload. Output is a SoF/Val/EoF/Err
// byte stream with no backpressure.
//
// Ports
//   Clk, Rst        clock, synchronous active-high reset
//   StartIn         one-cycle frame request, honoured only when idle
//   PayloadLenIn    L4 payload length in bytes (0..MAX_PAYLOAD)
//   ProtocolIn      IPv4 protocol field
//   LocalIPIn       source address
//   RemoteIPIn      destination address
//   BusyOut         frame in progress (until the cycle after EoFOut)
//   StartErrOut     one-cycle pulse: request rejected, length too large
//   RdyOut          payload pull; a byte is taken on ValIn && RdyOut
//   ValIn, EoFIn    payload byte valid / last payload byte
//   DataIn          payload byte
//   SoFOut, ValOut  first header byte / output byte valid
//   EoFOut, ErrOut  last output byte / EoF mismatch (valid with EoFOut)
//   DataOut         output byte
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for StartIn
// CALC  | 10 cycles summing header words into the checksum accumulator
// HDR   | 20 cycles, header byte cnt is on DataOut
// PAY   | RdyOut high, accepted payload bytes forwarded one cycle later

module frame_l3_tx #(
    parameter logic [7:0]  TTL         = 8'h40,
    parameter bit          DF          = 1'b1,
    parameter int          MAX_PAYLOAD = 1480,
    parameter logic [15:0] ID_INIT     = 16'h0000
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        StartIn,
    input  logic [15:0] PayloadLenIn,
    input  logic [7:0]  ProtocolIn,
    input  logic [31:0] LocalIPIn,
    input  logic [31:0] RemoteIPIn,
    output logic        BusyOut,
    output logic        StartErrOut,
    output logic        RdyOut,
    input  logic        ValIn,
    input  logic        EoFIn,
    input  logic [7:0]  DataIn,
    output logic        SoFOut,
    output logic        ValOut,
    output logic        EoFOut,
    output logic        ErrOut,
    output logic [7:0]  DataOut
);

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_HDR, S_PAY} state_t;

    state_t      state, state_n;

    logic [15:0] total_len;
    logic [15:0] pay_len;
    logic [7:0]  proto;
    logic [31:0] src_ip;
    logic [31:0] dst_ip;
    logic [15:0] id_cnt, id_n;
    logic [4:0]  cnt, cnt_n;
    logic [15:0] pay_cnt, pay_cnt_n;
    logic [19:0] acc, acc_n;
    logic [15:0] cksum, cksum_n;

    logic        busy_n, start_err_n, sof_n, val_n, eof_n, err_n;
    logic [7:0]  data_n;
    logic        take_start;
    logic        len_ok;
    logic        pay_last;
    logic [15:0] calc_word;
    logic [4:0]  hdr_idx;
    logic [7:0]  hdr_byte;
    logic [19:0] sum_full, fold1, fold2;

    assign len_ok   = (PayloadLenIn <= 16'(MAX_PAYLOAD));
    assign pay_last = ((pay_cnt + 16'd1) == pay_len);
    assign RdyOut   = (state == S_PAY);

    // Header words in transmit order; the checksum word is summed as zero.
    always_comb begin
        calc_word = 16'h0000;
        case (cnt)
            5'd0:    calc_word = 16'h4500;
            5'd1:    calc_word = total_len;
            5'd2:    calc_word = id_cnt;
            5'd3:    calc_word = {1'b0, DF, 14'h0};
            5'd4:    calc_word = {TTL, proto};
            5'd5:    calc_word = 16'h0000;
            5'd6:    calc_word = src_ip[31:16];
            5'd7:    calc_word = src_ip[15:0];
            5'd8:    calc_word = dst_ip[31:16];
            5'd9:    calc_word = dst_ip[15:0];
            default: calc_word = 16'h0000;
        endcase
    end

    // Byte registered during HDR index cnt is the one shown next cycle.
    assign hdr_idx = cnt + 5'd1;

    always_comb begin
        hdr_byte = 8'h00;
        case (hdr_idx)
            5'd0:    hdr_byte = 8'h45;
            5'd1:    hdr_byte = 8'h00;
            5'd2:    hdr_byte = total_len[15:8];
            5'd3:    hdr_byte = total_len[7:0];
            5'd4:    hdr_byte = id_cnt[15:8];
            5'd5:    hdr_byte = id_cnt[7:0];
            5'd6:    hdr_byte = {1'b0, DF, 6'h0};
            5'd7:    hdr_byte = 8'h00;
            5'd8:    hdr_byte = TTL;
            5'd9:    hdr_byte = proto;
            5'd10:   hdr_byte = cksum[15:8];
            5'd11:   hdr_byte = cksum[7:0];
            5'd12:   hdr_byte = src_ip[31:24];
            5'd13:   hdr_byte = src_ip[23:16];
            5'd14:   hdr_byte = src_ip[15:8];
            5'd15:   hdr_byte = src_ip[7:0];
            5'd16:   hdr_byte = dst_ip[31:24];
            5'd17:   hdr_byte = dst_ip[23:16];
            5'd18:   hdr_byte = dst_ip[15:8];
            5'd19:   hdr_byte = dst_ip[7:0];
            default: hdr_byte = 8'h00;
        endcase
    end

    // Two end-around folds are enough for a sum of ten 16-bit words.
    assign sum_full = acc + {4'h0, calc_word};
    assign fold1    = {4'h0, sum_full[15:0]} + {16'h0, sum_full[19:16]};
    assign fold2    = {4'h0, fold1[15:0]} + {16'h0, fold1[19:16]};

    always_comb begin
        state_n     = state;
        busy_n      = BusyOut;
        start_err_n = 1'b0;
        sof_n       = 1'b0;
        val_n       = 1'b0;
        eof_n       = 1'b0;
        err_n       = 1'b0;
        data_n      = 8'h00;
        cnt_n       = cnt;
        pay_cnt_n   = pay_cnt;
        acc_n       = acc;
        cksum_n     = cksum;
        id_n        = id_cnt;
        take_start  = 1'b0;

        // Busy drops the cycle after the last byte; StartIn is held off
        // until then even though the FSM is already idle.
        if (EoFOut) begin
            busy_n = 1'b0;
        end

        case (state)
            S_IDLE: begin
                if (StartIn && !BusyOut) begin
                    if (len_ok) begin
                        take_start = 1'b1;
                        busy_n     = 1'b1;
                        cnt_n      = 5'd0;
                        acc_n      = 20'h0;
                        state_n    = S_CALC;
                    end else begin
                        start_err_n = 1'b1;
                    end
                end
            end
            S_CALC: begin
                acc_n = sum_full;
                cnt_n = cnt + 5'd1;
                if (cnt == 5'd9) begin
                    cksum_n = ~fold2[15:0];
                    cnt_n   = 5'd0;
                    sof_n   = 1'b1;
                    val_n   = 1'b1;
                    data_n  = 8'h45;
                    state_n = S_HDR;
                end
            end
            S_HDR: begin
                if (cnt != 5'd19) begin
                    val_n  = 1'b1;
                    data_n = hdr_byte;
                    cnt_n  = cnt + 5'd1;
                    if ((cnt == 5'd18) && (pay_len == 16'd0)) begin
                        eof_n = 1'b1;
                    end
                end else begin
                    id_n      = id_cnt + 16'd1;
                    pay_cnt_n = 16'd0;
                    state_n   = (pay_len == 16'd0) ? S_IDLE : S_PAY;
                end
            end
            S_PAY: begin
                if (ValIn) begin
                    val_n     = 1'b1;
                    data_n    = DataIn;
                    pay_cnt_n = pay_cnt + 16'd1;
                    if (pay_last || EoFIn) begin
                        eof_n   = 1'b1;
                        err_n   = !(pay_last && EoFIn);
                        state_n = S_IDLE;
                    end
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state       <= S_IDLE;
            BusyOut     <= 1'b0;
            StartErrOut <= 1'b0;
            SoFOut      <= 1'b0;
            ValOut      <= 1'b0;
            EoFOut      <= 1'b0;
            ErrOut      <= 1'b0;
            DataOut     <= 8'h00;
            cnt         <= 5'd0;
            pay_cnt     <= 16'd0;
            acc         <= 20'h0;
            cksum       <= 16'h0;
            id_cnt      <= ID_INIT;
            total_len   <= 16'd0;
            pay_len     <= 16'd0;
            proto       <= 8'h00;
            src_ip      <= 32'h0;
            dst_ip      <= 32'h0;
        end else begin
            state       <= state_n;
            BusyOut     <= busy_n;
            StartErrOut <= start_err_n;
            SoFOut      <= sof_n;
            ValOut      <= val_n;
            EoFOut      <= eof_n;
            ErrOut      <= err_n;
            DataOut     <= data_n;
            cnt         <= cnt_n;
            pay_cnt     <= pay_cnt_n;
            acc         <= acc_n;
            cksum       <= cksum_n;
            id_cnt      <= id_n;
            if (take_start) begin
                total_len <= PayloadLenIn + 16'd20;
                pay_len   <= PayloadLenIn;
                proto     <= ProtocolIn;
                src_ip    <= LocalIPIn;
                dst_ip    <= RemoteIPIn;
            end
        end
    end

endmodule

// File: tb/tb_frame_l3_tx.sv
// tb_frame_l3_tx - directed bench for the IPv4 transmit framer.
// All checksums below are worked out by hand from the header words.

module tb_frame_l3_tx;

    logic        Clk = 1'b0;
    logic        Rst;
    logic        StartIn;
    logic [15:0] PayloadLenIn;
    logic [7:0]  ProtocolIn;
    logic [31:0] LocalIPIn;
    logic [31:0] RemoteIPIn;
    logic        BusyOut;
    logic        StartErrOut;
    logic        RdyOut;
    logic        ValIn;
    logic        EoFIn;
    logic [7:0]  DataIn;
    logic        SoFOut;
    logic        ValOut;
    logic        EoFOut;
    logic        ErrOut;
    logic [7:0]  DataOut;

    frame_l3_tx dut (
        .Clk          (Clk),
        .Rst          (Rst),
        .StartIn      (StartIn),
        .PayloadLenIn (PayloadLenIn),
        .ProtocolIn   (ProtocolIn),
        .LocalIPIn    (LocalIPIn),
        .RemoteIPIn   (RemoteIPIn),
        .BusyOut      (BusyOut),
        .StartErrOut  (StartErrOut),
        .RdyOut       (RdyOut),
        .ValIn        (ValIn),
        .EoFIn        (EoFIn),
        .DataIn       (DataIn),
        .SoFOut       (SoFOut),
        .ValOut       (ValOut),
        .EoFOut       (EoFOut),
        .ErrOut       (ErrOut),
        .DataOut      (DataOut)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic [7:0] data;
        logic       sof;
        logic       eof;
        logic       err;
        int         cyc;
    } obs_t;

    int         cyc = 0;
    int         n_cmp = 0;
    int         n_bad = 0;
    obs_t       obs[$];
    logic [7:0] exp_data[0:63];
    int         exp_n;
    bit         exp_err;
    int         acc_cyc[0:63];
    int         n_acc;
    bit         rdy_seen, busy_seen, busy_q;
    int         busy_fall_cyc = -1;

    always @(posedge Clk) cyc <= cyc + 1;

    always @(negedge Clk) begin
        if (ValOut) obs.push_back('{DataOut, SoFOut, EoFOut, ErrOut, cyc});
        if (RdyOut) rdy_seen = 1'b1;
        if (BusyOut) busy_seen = 1'b1;
        if (busy_q && !BusyOut) busy_fall_cyc = cyc;
        busy_q = BusyOut;
    end

    // Builds the expected byte list; header uses the fixed test addresses.
    task automatic fill_exp(input logic [15:0] tl, input logic [15:0] id, input logic [7:0] proto,
                            input logic [15:0] ck, input int n_pay, input logic [7:0] base, input bit err_last);
        logic [7:0] h[20];
        h = '{8'h45, 8'h00, tl[15:8], tl[7:0], id[15:8], id[7:0], 8'h40, 8'h00, 8'h40, proto,
              ck[15:8], ck[7:0], 8'hC0, 8'hA8, 8'h01, 8'h0A, 8'hC0, 8'hA8, 8'h01, 8'h01};
        for (int i = 0; i < 20; i++) exp_data[i] = h[i];
        for (int j = 0; j < n_pay; j++) exp_data[20 + j] = base + j[7:0];
        exp_n   = 20 + n_pay;
        exp_err = err_last;
    endtask

    task automatic start_frame(input logic [15:0] len, input logic [7:0] proto);
        @(negedge Clk);
        StartIn      = 1'b1;
        PayloadLenIn = len;
        ProtocolIn   = proto;
        LocalIPIn    = 32'hC0A8010A;
        RemoteIPIn   = 32'hC0A80101;
        @(negedge Clk);
        StartIn = 1'b0;
    endtask

    // Offers n_offer bytes (base+idx); EoFIn on byte number eof_at (0 = never).
    task automatic drive_payload(input int n_offer, input int eof_at, input bit gappy,
                                 input logic [7:0] base, input int budget);
        int idx = 0;
        bit phase = 1'b1;
        n_acc = 0;
        for (int k = 0; k < budget && idx < n_offer; k++) begin
            @(negedge Clk);
            ValIn  = gappy ? phase : 1'b1;
            phase  = ~phase;
            DataIn = base + idx[7:0];
            EoFIn  = ((idx + 1) == eof_at);
            if (ValIn && RdyOut) begin
                acc_cyc[idx] = cyc;
                idx++;
                n_acc = idx;
            end
        end
        @(negedge Clk);
        ValIn = 1'b0;
        EoFIn = 1'b0;
    endtask

    task automatic test_reset();
        Rst = 1'b1;
        repeat (3) @(negedge Clk);
        n_cmp++;
        if ({SoFOut, ValOut, EoFOut, ErrOut, DataOut, BusyOut, RdyOut, StartErrOut} !== 15'h0) begin
            n_bad++;
            $display("FAIL reset_outputs: got %h, want 0",
                     {SoFOut, ValOut, EoFOut, ErrOut, DataOut, BusyOut, RdyOut, StartErrOut});
        end
        Rst = 1'b0;
        repeat (2) @(negedge Clk);
        n_cmp++;
        if ({ValOut, BusyOut, RdyOut} !== 3'b000) begin
            n_bad++;
            $display("FAIL idle_after_reset: got %b, want 000", {ValOut, BusyOut, RdyOut});
        end
    endtask

    task automatic test_back_to_back();
        obs.delete();
        start_frame(16'd8, 8'd17);
        n_cmp++;
        if (BusyOut !== 1'b1) begin
            n_bad++;
            $display("FAIL busy_rise: got %b, want 1", BusyOut);
        end
        drive_payload(8, 8, 1'b0, 8'h10, 80);
        n_cmp++;
        if ({EoFOut, BusyOut, RdyOut} !== 3'b110) begin
            n_bad++;
            $display("FAIL f1_end_eof_busy_rdy: got %b, want 110", {EoFOut, BusyOut, RdyOut});
        end
        @(negedge Clk);
        n_cmp++;
        if (BusyOut !== 1'b0) begin
            n_bad++;
            $display("FAIL busy_fall: got %b, want 0", BusyOut);
        end
        StartIn = 1'b1;
        fill_exp(16'h001C, 16'h0000, 8'h11, 16'hB775, 8, 8'h10, 1'b0);
        n_cmp++;
        if (obs.size() != exp_n) begin
            n_bad++;
            $display("FAIL f1_count: got %0d bytes, want %0d", obs.size(), exp_n);
        end
        for (int i = 0; i < exp_n && i < obs.size(); i++) begin
            n_cmp++;
            if ({obs[i].data, obs[i].sof, obs[i].eof, obs[i].err} !==
                {exp_data[i], i == 0, i == exp_n - 1, exp_err && (i == exp_n - 1)}) begin
                n_bad++;
                $display("FAIL f1_byte%0d: got %h/%b%b%b, want %h", i, obs[i].data,
                         obs[i].sof, obs[i].eof, obs[i].err, exp_data[i]);
            end
        end
        for (int i = 1; i < 20 && i < obs.size(); i++) begin
            n_cmp++;
            if (obs[i].cyc != obs[i-1].cyc + 1) begin
                n_bad++;
                $display("FAIL f1_hdr_gap%0d: got cycle %0d, want %0d", i, obs[i].cyc, obs[i-1].cyc + 1);
            end
        end
        for (int j = 0; j < n_acc && 20 + j < obs.size(); j++) begin
            n_cmp++;
            if (obs[20 + j].cyc != acc_cyc[j] + 1) begin
                n_bad++;
                $display("FAIL f1_latency%0d: got cycle %0d, want %0d", j, obs[20 + j].cyc, acc_cyc[j] + 1);
            end
        end
        obs.delete();
        @(negedge Clk);
        StartIn = 1'b0;
        n_cmp++;
        if (BusyOut !== 1'b1) begin
            n_bad++;
            $display("FAIL busy_low_one_cycle: got %b, want 1", BusyOut);
        end
        drive_payload(8, 8, 1'b0, 8'h20, 80);
        repeat (3) @(negedge Clk);
        fill_exp(16'h001C, 16'h0001, 8'h11, 16'hB774, 8, 8'h20, 1'b0);
        n_cmp++;
        if (obs.size() != exp_n) begin
            n_bad++;
            $display("FAIL f2_count: got %0d bytes, want %0d", obs.size(), exp_n);
        end
        for (int i = 0; i < exp_n && i < obs.size(); i++) begin
            n_cmp++;
            if ({obs[i].data, obs[i].sof, obs[i].eof, obs[i].err} !==
                {exp_data[i], i == 0, i == exp_n - 1, exp_err && (i == exp_n - 1)}) begin
                n_bad++;
                $display("FAIL f2_byte%0d: got %h/%b%b%b, want %h", i, obs[i].data,
                         obs[i].sof, obs[i].eof, obs[i].err, exp_data[i]);
            end
        end
    endtask

    task automatic test_gaps();
        obs.delete();
        start_frame(16'd8, 8'd6);
        drive_payload(8, 8, 1'b1, 8'h30, 120);
        n_cmp++;
        if (RdyOut !== 1'b0) begin
            n_bad++;
            $display("FAIL gaps_rdy_drop: got %b, want 0", RdyOut);
        end
        repeat (3) @(negedge Clk);
        fill_exp(16'h001C, 16'h0002, 8'h06, 16'hB77E, 8, 8'h30, 1'b0);
        n_cmp++;
        if (obs.size() != exp_n) begin
            n_bad++;
            $display("FAIL gaps_count: got %0d bytes, want %0d", obs.size(), exp_n);
        end
        for (int i = 0; i < exp_n && i < obs.size(); i++) begin
            n_cmp++;
            if ({obs[i].data, obs[i].sof, obs[i].eof, obs[i].err} !==
                {exp_data[i], i == 0, i == exp_n - 1, exp_err && (i == exp_n - 1)}) begin
                n_bad++;
                $display("FAIL gaps_byte%0d: got %h/%b%b%b, want %h", i, obs[i].data,
                         obs[i].sof, obs[i].eof, obs[i].err, exp_data[i]);
            end
        end
        for (int j = 0; j < n_acc && 20 + j < obs.size(); j++) begin
            n_cmp++;
            if (obs[20 + j].cyc != acc_cyc[j] + 1) begin
                n_bad++;
                $display("FAIL gaps_latency%0d: got cycle %0d, want %0d", j, obs[20 + j].cyc, acc_cyc[j] + 1);
            end
        end
        n_cmp++;
        if (obs.size() < 22 || obs[21].cyc - obs[20].cyc != 2) begin
            n_bad++;
            $display("FAIL gaps_spacing: got %0d bytes, want payload bytes 2 cycles apart", obs.size());
        end
    endtask

    task automatic test_early_eof();
        obs.delete();
        start_frame(16'd8, 8'd17);
        drive_payload(8, 5, 1'b0, 8'h40, 80);
        n_cmp++;
        if (n_acc != 5) begin
            n_bad++;
            $display("FAIL early_accepted: got %0d, want 5", n_acc);
        end
        n_cmp++;
        if ({BusyOut, RdyOut} !== 2'b00) begin
            n_bad++;
            $display("FAIL early_idle: got busy/rdy %b, want 00", {BusyOut, RdyOut});
        end
        fill_exp(16'h001C, 16'h0003, 8'h11, 16'hB772, 5, 8'h40, 1'b1);
        n_cmp++;
        if (obs.size() != exp_n) begin
            n_bad++;
            $display("FAIL early_count: got %0d bytes, want %0d", obs.size(), exp_n);
        end
        for (int i = 0; i < exp_n && i < obs.size(); i++) begin
            n_cmp++;
            if ({obs[i].data, obs[i].sof, obs[i].eof, obs[i].err} !==
                {exp_data[i], i == 0, i == exp_n - 1, exp_err && (i == exp_n - 1)}) begin
                n_bad++;
                $display("FAIL early_byte%0d: got %h/%b%b%b, want %h", i, obs[i].data,
                         obs[i].sof, obs[i].eof, obs[i].err, exp_data[i]);
            end
        end
        obs.delete();
        start_frame(16'd8, 8'd17);
        drive_payload(9, 0, 1'b0, 8'h50, 80);
        n_cmp++;
        if (n_acc != 8) begin
            n_bad++;
            $display("FAIL noeof_accepted: got %0d, want 8", n_acc);
        end
        fill_exp(16'h001C, 16'h0004, 8'h11, 16'hB771, 8, 8'h50, 1'b1);
        n_cmp++;
        if (obs.size() != exp_n) begin
            n_bad++;
            $display("FAIL noeof_count: got %0d bytes, want %0d", obs.size(), exp_n);
        end
        for (int i = 0; i < exp_n && i < obs.size(); i++) begin
            n_cmp++;
            if ({obs[i].data, obs[i].sof, obs[i].eof, obs[i].err} !==
                {exp_data[i], i == 0, i == exp_n - 1, exp_err && (i == exp_n - 1)}) begin
                n_bad++;
                $display("FAIL noeof_byte%0d: got %h/%b%b%b, want %h", i, obs[i].data,
                         obs[i].sof, obs[i].eof, obs[i].err, exp_data[i]);
            end
        end
    endtask

    task automatic test_len_bounds();
        obs.delete();
        rdy_seen = 1'b0;
        start_frame(16'd0, 8'd17);
        repeat (40) @(negedge Clk);
        fill_exp(16'h0014, 16'h0005, 8'h11, 16'hB778, 0, 8'h00, 1'b0);
        n_cmp++;
        if (obs.size() != exp_n) begin
            n_bad++;
            $display("FAIL len0_count: got %0d bytes, want %0d", obs.size(), exp_n);
        end
        for (int i = 0; i < exp_n && i < obs.size(); i++) begin
            n_cmp++;
            if ({obs[i].data, obs[i].sof, obs[i].eof, obs[i].err} !==
                {exp_data[i], i == 0, i == exp_n - 1, exp_err && (i == exp_n - 1)}) begin
                n_bad++;
                $display("FAIL len0_byte%0d: got %h/%b%b%b, want %h", i, obs[i].data,
                         obs[i].sof, obs[i].eof, obs[i].err, exp_data[i]);
            end
        end
        n_cmp++;
        if (rdy_seen) begin
            n_bad++;
            $display("FAIL len0_rdy: got RdyOut high, want never");
        end
        n_cmp++;
        if (obs.size() < 20 || busy_fall_cyc != obs[19].cyc + 1) begin
            n_bad++;
            $display("FAIL len0_busy_fall: got cycle %0d, want one after EoF", busy_fall_cyc);
        end
        obs.delete();
        busy_seen = 1'b0;
        start_frame(16'd1481, 8'd17);
        n_cmp++;
        if ({StartErrOut, BusyOut} !== 2'b10) begin
            n_bad++;
            $display("FAIL too_long_pulse: got err/busy %b, want 10", {StartErrOut, BusyOut});
        end
        @(negedge Clk);
        n_cmp++;
        if (StartErrOut !== 1'b0) begin
            n_bad++;
            $display("FAIL too_long_pulse_width: got %b, want 0", StartErrOut);
        end
        repeat (40) @(negedge Clk);
        n_cmp++;
        if (obs.size() != 0 || busy_seen) begin
            n_bad++;
            $display("FAIL too_long_quiet: got %0d bytes busy=%b, want 0 bytes busy=0", obs.size(), busy_seen);
        end
    endtask

    task automatic test_reset_mid();
        int hb = 0;
        obs.delete();
        start_frame(16'd1480, 8'd17);
        for (int k = 0; k < 60 && hb < 11; k++) begin
            @(negedge Clk);
            if (ValOut) hb++;
        end
        n_cmp++;
        if (hb != 11 || DataOut !== 8'hB1) begin
            n_bad++;
            $display("FAIL max_len_byte10: got %0d bytes last %h, want 11 bytes last b1", hb, DataOut);
        end
        Rst = 1'b1;
        @(negedge Clk);
        n_cmp++;
        if ({SoFOut, ValOut, EoFOut, ErrOut, DataOut, BusyOut, RdyOut, StartErrOut} !== 15'h0) begin
            n_bad++;
            $display("FAIL midreset_outputs: got %h, want 0",
                     {SoFOut, ValOut, EoFOut, ErrOut, DataOut, BusyOut, RdyOut, StartErrOut});
        end
        Rst = 1'b0;
        n_cmp++;
        if (obs.size() < 4 || {obs[2].data, obs[3].data} !== 16'h05DC) begin
            n_bad++;
            $display("FAIL max_len_total: got %0d bytes, want total length 05dc", obs.size());
        end
        for (int i = 0; i < obs.size(); i++) begin
            n_cmp++;
            if (obs[i].eof !== 1'b0) begin
                n_bad++;
                $display("FAIL midreset_eof%0d: got 1, want 0", i);
            end
        end
        repeat (2) @(negedge Clk);
        obs.delete();
        start_frame(16'd8, 8'd17);
        drive_payload(8, 8, 1'b0, 8'h60, 80);
        repeat (3) @(negedge Clk);
        fill_exp(16'h001C, 16'h0000, 8'h11, 16'hB775, 8, 8'h60, 1'b0);
        n_cmp++;
        if (obs.size() != exp_n) begin
            n_bad++;
            $display("FAIL postreset_count: got %0d bytes, want %0d", obs.size(), exp_n);
        end
        for (int i = 0; i < exp_n && i < obs.size(); i++) begin
            n_cmp++;
            if ({obs[i].data, obs[i].sof, obs[i].eof, obs[i].err} !==
                {exp_data[i], i == 0, i == exp_n - 1, exp_err && (i == exp_n - 1)}) begin
                n_bad++;
                $display("FAIL postreset_byte%0d: got %h/%b%b%b, want %h", i, obs[i].data,
                         obs[i].sof, obs[i].eof, obs[i].err, exp_data[i]);
            end
        end
    endtask

    initial begin
        Rst          = 1'b1;
        StartIn      = 1'b0;
        PayloadLenIn = 16'd0;
        ProtocolIn   = 8'd0;
        LocalIPIn    = 32'h0;
        RemoteIPIn   = 32'h0;
        ValIn        = 1'b0;
        EoFIn        = 1'b0;
        DataIn       = 8'h00;
        test_reset();
        test_back_to_back();
        test_gaps();
        test_early_eof();
        test_len_bounds();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish by 200000 ns, want finish");
        $fatal(1);
    end

endmodule
